imem_boot_loader: RTL and testbench

// - Boot-time controller that fills the 256-word instruction memory from a byte stream.
// - Sequences the memory write port: packs bytes into little-endian words, generates

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/imem_boot_loader_word_packer.sv | 42 ++++
 rtl/imem_boot_loader.sv | 138 +++++++++++++
 tb/tb_imem_boot_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Also meant to be imported by the instruction memory for its depth/index width.
package imem_boot_loader_pkg;

   localparam int unsigned IMEM_DEPTH  = 256;
   localparam int unsigned IMEM_ADDR_W = 8;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned WORD_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port.
//   rx_valid/rx_data : stream byte offered by the host/UART path
//   rx_ready         : loader accepts the byte this cycle
//   mem_we           : one-cycle write strobe per packed word
//   mem_addr         : word-aligned byte address of the write
//   mem_wdata        : little-endian packed word
// slave  = loader side, master = host + memory side.
interface imem_boot_loader_if;
   import imem_boot_loader_pkg::*;

   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   modport slave  (input  rx_valid, rx_data,
                   output rx_ready, mem_we, mem_addr, mem_wdata);

   modport master (output rx_valid, rx_data,
                   input  rx_ready, mem_we, mem_addr, mem_wdata);

endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// Packs a byte stream into little-endian 32-bit words.
//   clk        : rising-edge clock
//   clear      : synchronous clear of byte index and partial word
//   byte_valid : accept byte_data this cycle
//   byte_data  : incoming byte
//   word_valid : high in the cycle the 4th byte of a word is accepted
//   word       : completed word, valid together with word_valid
module word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic              clk,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [1:0]  idx_q;
   logic [23:0] acc_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         idx_q <= '0;
         acc_q <= '0;
      end else if (byte_valid) begin
         idx_q <= idx_q + 2'd1;
         case (idx_q)
            2'd0:    acc_q[7:0]   <= byte_data;
            2'd1:    acc_q[15:8]  <= byte_data;
            2'd2:    acc_q[23:16] <= byte_data;
            default: ;
         endcase
      end
   end

   // The 4th byte bypasses the accumulator so the word is complete in the
   // same cycle as its last handshake.
   assign word_valid = byte_valid && (idx_q == 2'd3);
   assign word       = {byte_data, acc_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: fills the instruction memory from a length-prefixed byte stream
// and holds the CPU in stall until the image is loaded.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : one-cycle pulse that begins a load (ignored while busy)
//   bus          : rx byte handshake in, memory write port out
//   cpu_hold     : stall the processor (low only once the image is done)
//   busy         : header or data transfer in progress
//   done         : image fully written (level)
//   err_len      : sticky, header length exceeded DEPTH; cleared by start
//   words_loaded : words written in the current load
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned       DEPTH     = IMEM_DEPTH,
   parameter int unsigned       ADDR_W    = IMEM_ADDR_W,
   parameter logic [WORD_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   imem_boot_loader_if.slave bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic [ADDR_W:0]   words_loaded
);

   loader_state_t     state_q, state_d;
   logic              rx_ready;
   logic              xfer;
   logic              start_go;
   logic [15:0]       hdr_count;
   logic [7:0]        len_lo_q;
   logic [ADDR_W:0]   count_q;
   logic              mem_we_q;
   logic [WORD_W-1:0] mem_addr_q;
   logic [WORD_W-1:0] mem_wdata_q;
   logic              pk_clear;
   logic              pk_valid;
   logic              pk_word_valid;
   logic [WORD_W-1:0] pk_word;

   assign xfer      = bus.rx_valid && rx_ready;
   assign start_go  = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
   assign hdr_count = {bus.rx_data, len_lo_q};

   assign bus.rx_ready  = rx_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign pk_clear = reset || start_go;
   assign pk_valid = xfer && (state_q == ST_DATA);

   word_packer u_packer (
      .clk        (clk),
      .clear      (pk_clear),
      .byte_valid (pk_valid),
      .byte_data  (bus.rx_data),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      rx_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      cpu_hold = 1'b1;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LEN0;
         ST_LEN0: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (xfer) state_d = ST_LEN1;
         end
         ST_LEN1: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (xfer) begin
               if (hdr_count == 16'd0)             state_d = ST_DONE;
               else if (hdr_count > 16'(DEPTH))    state_d = ST_ERR;
               else                                state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            // Leave once the final word's write cycle is on the bus; the
            // counter already reflects that word.
            if (mem_we_q && (words_loaded == count_q)) state_d = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_d = ST_LEN0;
         end
         ST_ERR:  if (start) state_d = ST_LEN0;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= '0;
         err_len      <= 1'b0;
         words_loaded <= '0;
         len_lo_q     <= '0;
         count_q      <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (start_go) begin
            words_loaded <= '0;
            err_len      <= 1'b0;
         end
         if ((state_q == ST_LEN0) && xfer) len_lo_q <= bus.rx_data;
         if ((state_q == ST_LEN1) && xfer) begin
            count_q <= hdr_count[ADDR_W:0];
            if (hdr_count > 16'(DEPTH)) err_len <= 1'b1;
         end
         if (pk_word_valid) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= BASE_ADDR + WORD_W'({words_loaded, 2'b00});
            mem_wdata_q  <= pk_word;
            words_loaded <= words_loaded + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: drives length-prefixed byte streams,
// records every memory write at the falling edge and compares against
// hand-computed addresses/words.
module tb_imem_boot_loader;
   import imem_boot_loader_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       cpu_hold, busy, done, err_len;
   logic [8:0] words_loaded;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] wr_wl[$];

   imem_boot_loader_if bus ();

   imem_boot_loader u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (bus.slave),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .err_len      (err_len),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         wr_wl.push_back(32'(words_loaded));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_wl.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Offer one byte and hold it until a handshake edge; returns #1 after it.
   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (bus.rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rx_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int unsigned n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic check_wr(input string tag, input int unsigned i,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] wl);
      if (wr_addr.size() > i) begin
         check({tag, "_addr"}, wr_addr[i], addr);
         check({tag, "_data"}, wr_data[i], data);
         check({tag, "_wl"},   wr_wl[i],   wl);
      end else begin
         check({tag, "_missing"}, 32'(wr_addr.size()), 32'(i + 1));
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;

      // Reset, then idle
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_log();
      repeat (5) @(negedge clk);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_done",     32'(done), 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("rst_err_len",  32'(err_len), 32'd0);
      check("rst_words",    32'(words_loaded), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_no_writes", 32'(wr_addr.size()), 32'd0);

      // Two-word load
      clear_log();
      pulse_start();
      check("t2_busy", 32'(busy), 32'd1);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_done("t2_done");
      check("t2_nwr", 32'(wr_addr.size()), 32'd2);
      check_wr("t2_w0", 0, 32'h0, 32'h12345678, 32'd1);
      check_wr("t2_w1", 1, 32'h4, 32'hDEADBEEF, 32'd2);
      check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
      check("t2_busy_end", 32'(busy), 32'd0);
      check("t2_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("t2_words", 32'(words_loaded), 32'd2);

      // Zero-length header
      clear_log();
      pulse_start();
      check("t3_done_clr", 32'(done), 32'd0);
      check("t3_hold_set", 32'(cpu_hold), 32'd1);
      check("t3_words_clr", 32'(words_loaded), 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      check("t3_done", 32'(done), 32'd1);
      check("t3_words", 32'(words_loaded), 32'd0);
      check("t3_nwr", 32'(wr_addr.size()), 32'd0);

      // Oversized header (257)
      clear_log();
      pulse_start();
      send_byte(8'h01); send_byte(8'h01);
      check("t4_err_len", 32'(err_len), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_hold", 32'(cpu_hold), 32'd1);
      check("t4_done", 32'(done), 32'd0);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h55;
      repeat (3) begin
         @(negedge clk);
         check("t4_rx_ready", 32'(bus.rx_ready), 32'd0);
      end
      bus.rx_valid = 1'b0;
      check("t4_nwr", 32'(wr_addr.size()), 32'd0);
      pulse_start();
      check("t4_err_clr", 32'(err_len), 32'd0);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      wait_done("t4_done_1w");
      check("t4_nwr_1w", 32'(wr_addr.size()), 32'd1);
      check_wr("t4_w0", 0, 32'h0, 32'hDDCCBBAA, 32'd1);

      // Three words, rx_valid toggling, start ignored mid-DATA
      clear_log();
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      for (int i = 0; i < 12; i++) begin
         logic [7:0] b;
         b = 8'(8'h11 * (i + 1));
         send_byte(b);
         @(posedge clk);
         if (i == 5) begin
            pulse_start();
            check("t5_busy_after_start", 32'(busy), 32'd1);
         end
      end
      wait_done("t5_done");
      check("t5_nwr", 32'(wr_addr.size()), 32'd3);
      check_wr("t5_w0", 0, 32'h0, 32'h44332211, 32'd1);
      check_wr("t5_w1", 1, 32'h4, 32'h88776655, 32'd2);
      check_wr("t5_w2", 2, 32'h8, 32'hCCBBAA99, 32'd3);
      check("t5_words", 32'(words_loaded), 32'd3);

      // Reset during a 4-word load after 6 data bytes
      clear_log();
      pulse_start();
      send_byte(8'h04); send_byte(8'h00);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      @(negedge clk);
      check("t6_words_pre", 32'(words_loaded), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_hold", 32'(cpu_hold), 32'd1);
      check("t6_words", 32'(words_loaded), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h07;
      repeat (5) @(negedge clk);
      check("t6_rx_ready", 32'(bus.rx_ready), 32'd0);
      bus.rx_valid = 1'b0;
      check("t6_nwr", 32'(wr_addr.size()), 32'd1);
      check_wr("t6_w0", 0, 32'h0, 32'h04030201, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
